// File: rtl/bp_io_link_responder_pkg.sv
// Shared types for the IO link responder: opcodes, FSM states and a header
// struct macro sized by the cord, length and flit widths.
package bp_io_link_responder_pkg;

    typedef enum logic [1:0] {
        e_io_rd = 2'd0,
        e_io_wr = 2'd1
    } bp_io_resp_op_e;

    typedef enum logic [1:0] {
        e_hdr,
        e_data,
        e_resp_hdr,
        e_resp_data
    } bp_io_state_e;

    // Address bits left over in a header flit once the fixed fields are placed.
    function automatic int unsigned hdr_addr_width(int unsigned flit_w, int unsigned cord_w,
                                                   int unsigned len_w);
        return flit_w - 2 * cord_w - len_w - 3;
    endfunction

endpackage

// Header flit layout, LSB first: dst, len, src, opcode, err, addr.
`define BP_IO_HDR_S(cord_w, len_w, flit_w) \
    struct packed { \
        logic [(flit_w)-2*(cord_w)-(len_w)-4:0] addr; \
        logic                                   err; \
        logic [1:0]                             opcode; \
        logic [(cord_w)-1:0]                    src; \
        logic [(len_w)-1:0]                     len; \
        logic [(cord_w)-1:0]                    dst; \
    }

// File: rtl/bp_io_link_responder_if.sv
// Ready-and link bundle for the responder: cmd link in/out and resp link in/out.
// Each link is {v, data, ready_and_rev}.
interface bp_io_link_responder_if
    import bp_io_link_responder_pkg::*;
#(
    parameter int unsigned flit_width_p = 64
);
    logic [flit_width_p+1:0] io_cmd_link_i;
    logic [flit_width_p+1:0] io_cmd_link_o;
    logic [flit_width_p+1:0] io_resp_link_i;
    logic [flit_width_p+1:0] io_resp_link_o;

    modport slave (
        input  io_cmd_link_i,
        input  io_resp_link_i,
        output io_cmd_link_o,
        output io_resp_link_o
    );

    modport master (
        output io_cmd_link_i,
        output io_resp_link_i,
        input  io_cmd_link_o,
        input  io_resp_link_o
    );
endinterface

// File: rtl/bp_io_link_responder_regs.sv
// Register bank: one synchronous write port, one asynchronous read port,
// cleared by asynchronous reset.
module bp_io_link_responder_regs
    import bp_io_link_responder_pkg::*;
#(
    parameter int unsigned els_p        = 16,
    parameter int unsigned width_p      = 64,
    parameter int unsigned addr_width_p = $clog2(els_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    w_v_i,
    input  logic [addr_width_p-1:0] w_addr_i,
    input  logic [width_p-1:0]      w_data_i,
    input  logic [addr_width_p-1:0] r_addr_i,
    output logic [width_p-1:0]      r_data_o
);
    logic [els_p-1:0][width_p-1:0] mem_q;

    // Storage update on write strobe.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mem_q <= '0;
        end else if (w_v_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_q[r_addr_i];
endmodule

// File: rtl/bp_io_link_responder.sv
// IO link responder: accepts command packets, performs a register read/write
// and returns one response packet to the sender's cord.
// Optional: BP_IO_LINK_RESPONDER_STATS_EN adds a command counter at word index els_p.
module bp_io_link_responder
    import bp_io_link_responder_pkg::*;
#(
    parameter int unsigned flit_width_p = 64,
    parameter int unsigned cord_width_p = 8,
    parameter int unsigned len_width_p  = 4,
    parameter int unsigned els_p        = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [cord_width_p-1:0] my_cord_i,
    bp_io_link_responder_if.slave   link
);
    localparam int unsigned lg_els_lp     = $clog2(els_p);
    localparam int unsigned addr_width_lp = hdr_addr_width(flit_width_p, cord_width_p, len_width_p);
    localparam int unsigned hi_width_lp   = addr_width_lp - lg_els_lp;

    typedef `BP_IO_HDR_S(cord_width_p, len_width_p, flit_width_p) hdr_s;

    logic                    cmd_v, cmd_ready, resp_v, resp_ready;
    logic [flit_width_p-1:0] cmd_data, resp_data;
    hdr_s                    cmd_hdr, resp_hdr;

    assign cmd_v      = link.io_cmd_link_i[flit_width_p+1];
    assign cmd_data   = link.io_cmd_link_i[flit_width_p:1];
    assign resp_ready = link.io_resp_link_i[0];
    assign cmd_hdr    = cmd_data;

    assign link.io_cmd_link_o  = {1'b0, {flit_width_p{1'b0}}, cmd_ready};
    assign link.io_resp_link_o = {resp_v, resp_data, 1'b0};

    logic unused_ok;
    assign unused_ok = ^{link.io_cmd_link_i[0], link.io_resp_link_i[flit_width_p+1:1],
                         cmd_hdr.dst, cmd_hdr.err};

    bp_io_state_e            state_q, state_d;
    logic [cord_width_p-1:0] src_q;
    logic [1:0]              op_q;
    logic                    err_q, wr_ok_q, first_q;
    logic [len_width_p-1:0]  cnt_q;
    logic [lg_els_lp-1:0]    waddr_q;
    logic [flit_width_p-1:0] rdata_q;

    // Header decode, evaluated against the flit currently on the cmd link.
    logic                   is_rd, is_wr, in_range, addr_ok, hdr_err, wr_ok, stats_hit;
    logic [hi_width_lp-1:0] hi_addr;
    logic [flit_width_p-1:0] bank_rdata, rd_word;

    assign hi_addr  = cmd_hdr.addr[addr_width_lp-1:lg_els_lp];
    assign is_rd    = (cmd_hdr.opcode == e_io_rd);
    assign is_wr    = (cmd_hdr.opcode == e_io_wr);
    assign in_range = (hi_addr == '0);
`ifdef BP_IO_LINK_RESPONDER_STATS_EN
    logic [flit_width_p-1:0] stats_q;
    assign stats_hit = (hi_addr == hi_width_lp'(1)) && (cmd_hdr.addr[lg_els_lp-1:0] == '0);
    assign rd_word   = stats_hit ? stats_q : bank_rdata;

    // Count completed commands at each response header handshake.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stats_q <= '0;
        end else if (state_q == e_resp_hdr && resp_ready) begin
            stats_q <= stats_q + 1'b1;
        end
    end
`else
    assign stats_hit = 1'b0;
    assign rd_word   = bank_rdata;
`endif
    // The counter is readable only; a write there is an error.
    assign addr_ok = in_range | (stats_hit & is_rd);
    assign hdr_err = ~(is_rd | is_wr) | ~addr_ok | (is_wr & (cmd_hdr.len == '0));
    assign wr_ok   = is_wr & in_range & (cmd_hdr.len != '0);

    bp_io_link_responder_regs #(
        .els_p   (els_p),
        .width_p (flit_width_p)
    ) regs (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .w_v_i    (state_q == e_data && cmd_v && first_q && wr_ok_q),
        .w_addr_i (waddr_q),
        .w_data_i (cmd_data),
        .r_addr_i (cmd_hdr.addr[lg_els_lp-1:0]),
        .r_data_o (bank_rdata)
    );

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= e_hdr;
        else         state_q <= state_d;
    end

    // Latch command context on header accept; count down data flits.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            src_q   <= '0;
            op_q    <= '0;
            err_q   <= 1'b0;
            wr_ok_q <= 1'b0;
            first_q <= 1'b0;
            cnt_q   <= '0;
            waddr_q <= '0;
            rdata_q <= '0;
        end else if (state_q == e_hdr && cmd_v) begin
            src_q   <= cmd_hdr.src;
            op_q    <= cmd_hdr.opcode;
            err_q   <= hdr_err;
            wr_ok_q <= wr_ok;
            first_q <= 1'b1;
            cnt_q   <= cmd_hdr.len;
            waddr_q <= cmd_hdr.addr[lg_els_lp-1:0];
            rdata_q <= rd_word;
        end else if (state_q == e_data && cmd_v) begin
            first_q <= 1'b0;
            cnt_q   <= cnt_q - 1'b1;
        end
    end

    // Next state and link outputs; valid depends only on state.
    always_comb begin
        state_d         = state_q;
        cmd_ready       = 1'b0;
        resp_v          = 1'b0;
        resp_data       = '0;
        resp_hdr        = '0;
        resp_hdr.dst    = src_q;
        resp_hdr.src    = my_cord_i;
        resp_hdr.opcode = op_q;
        resp_hdr.err    = err_q;
        resp_hdr.len[0] = (op_q == e_io_rd) & ~err_q;
        unique case (state_q)
            e_hdr: begin
                cmd_ready = 1'b1;
                if (cmd_v) state_d = (cmd_hdr.len == '0) ? e_resp_hdr : e_data;
            end
            e_data: begin
                cmd_ready = 1'b1;
                if (cmd_v && cnt_q == len_width_p'(1)) state_d = e_resp_hdr;
            end
            e_resp_hdr: begin
                resp_v    = 1'b1;
                resp_data = resp_hdr;
                if (resp_ready) state_d = resp_hdr.len[0] ? e_resp_data : e_hdr;
            end
            e_resp_data: begin
                resp_v    = 1'b1;
                resp_data = rdata_q;
                if (resp_ready) state_d = e_hdr;
            end
            default: state_d = e_hdr;
        endcase
    end
endmodule

// File: tb/tb_bp_io_link_responder.sv
// Scoreboard bench for bp_io_link_responder: the stimulus thread queues the
// expected response flits, a monitor pops and compares each delivered flit.
module tb_bp_io_link_responder;
    import bp_io_link_responder_pkg::*;

    localparam logic [7:0] MyCord = 8'h3C;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_v;
    logic [63:0] cmd_data;
    logic        resp_ready;
    logic        cmd_ready, resp_v;
    logic [63:0] resp_data;

    bp_io_link_responder_if #(.flit_width_p(64)) link ();

    assign link.io_cmd_link_i  = {cmd_v, cmd_data, 1'b0};
    assign link.io_resp_link_i = {1'b0, 64'h0, resp_ready};
    assign cmd_ready = link.io_cmd_link_o[0];
    assign resp_v    = link.io_resp_link_o[65];
    assign resp_data = link.io_resp_link_o[64:1];

    bp_io_link_responder #(
        .flit_width_p (64),
        .cord_width_p (8),
        .len_width_p  (4),
        .els_p        (16)
    ) dut (
        .clk_i     (clk),
        .reset_i   (rst),
        .my_cord_i (MyCord),
        .link      (link)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          resp_count = 0;
    logic [63:0] exp_q[$];

    function automatic logic [63:0] mk_hdr(logic [7:0] dst, logic [3:0] len, logic [7:0] src,
                                           logic [1:0] op, logic err, int addr);
        logic [40:0] a;
        a = 41'(addr);
        return {a, err, op, src, len, dst};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    // Monitor: compare every flit the DUT hands over.
    always @(negedge clk) begin
        if (!rst && resp_v && resp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got %h expected none", resp_data);
            end else begin
                check("resp_flit", resp_data, exp_q.pop_front());
            end
            resp_count++;
        end
    end

    task automatic send_flit(input logic [63:0] d);
        int t;
        cmd_v    = 1'b1;
        cmd_data = d;
        t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) timeout("cmd_accept");
        @(posedge clk);
        #1;
        cmd_v = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (exp_q.size() != 0) begin
            timeout("resp_drain");
            exp_q.delete();
        end
    endtask

    task automatic rd(input logic [7:0] src, input int addr, input logic err,
                      input logic [63:0] data);
        exp_q.push_back(mk_hdr(src, err ? 4'd0 : 4'd1, MyCord, 2'd0, err, 0));
        if (!err) exp_q.push_back(data);
        send_flit(mk_hdr(MyCord, 4'd0, src, 2'd0, 1'b0, addr));
        wait_drain();
    endtask

    task automatic wr(input logic [7:0] src, input int addr, input logic [3:0] len,
                      input logic [63:0] data, input logic err);
        exp_q.push_back(mk_hdr(src, 4'd0, MyCord, 2'd1, err, 0));
        send_flit(mk_hdr(MyCord, len, src, 2'd1, 1'b0, addr));
        for (int i = 0; i < int'(len); i++) send_flit(data + 64'(i));
        wait_drain();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int c0;

    initial begin
        cmd_v      = 1'b0;
        cmd_data   = '0;
        resp_ready = 1'b1;
        rst        = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_resp_v", 64'(resp_v), 64'd0);
        check("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        check("reset_cmd_link_v", 64'(link.io_cmd_link_o[65]), 64'd0);
        check("reset_resp_link_ready", 64'(link.io_resp_link_o[0]), 64'd0);
        rst = 1'b0;

        // Write then read back.
        wr(8'h05, 3, 4'd1, 64'hDEADBEEF, 1'b0);
        rd(8'h05, 3, 1'b0, 64'hDEADBEEF);

        // Response backpressure over a read.
        resp_ready = 1'b0;
        exp_q.push_back(mk_hdr(8'h07, 4'd1, MyCord, 2'd0, 1'b0, 0));
        exp_q.push_back(64'hDEADBEEF);
        send_flit(mk_hdr(MyCord, 4'd0, 8'h07, 2'd0, 1'b0, 3));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_resp_v", 64'(resp_v), 64'd1);
            check("stall_resp_hdr", resp_data, mk_hdr(8'h07, 4'd1, MyCord, 2'd0, 1'b0, 0));
            check("stall_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        c0 = resp_count;
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        wait_drain();
        check("stall_flit_count", 64'(resp_count - c0), 64'd2);

        // Illegal opcode with two data flits drained.
        exp_q.push_back(mk_hdr(8'h09, 4'd0, MyCord, 2'd3, 1'b1, 0));
        send_flit(mk_hdr(MyCord, 4'd2, 8'h09, 2'd3, 1'b0, 1));
        send_flit(64'h1111);
        send_flit(64'h2222);
        wait_drain();
        rd(8'h09, 1, 1'b0, 64'h0);

        // Write with no data flit is an error; nothing written.
        wr(8'h0A, 5, 4'd0, 64'h0, 1'b1);
        rd(8'h0A, 5, 1'b0, 64'h0);

        // Maximum length write: only the first flit lands.
        wr(8'h0B, 0, 4'd15, 64'd1, 1'b0);
        rd(8'h0B, 0, 1'b0, 64'd1);
        rd(8'h0B, 3, 1'b0, 64'hDEADBEEF);

        // Word index els_p: error on write, bank index 0 untouched.
        wr(8'h0C, 16, 4'd1, 64'hAAAA_5555, 1'b1);
        rd(8'h0C, 0, 1'b0, 64'd1);
`ifndef BP_IO_LINK_RESPONDER_STATS_EN
        rd(8'h0C, 16, 1'b1, 64'h0);
`endif

        // Asynchronous reset after the header of a len=3 write.
        send_flit(mk_hdr(MyCord, 4'd3, 8'h0D, 2'd1, 1'b0, 2));
        #3;
        rst = 1'b1;
        #1;
        check("midreset_resp_v", 64'(resp_v), 64'd0);
        check("midreset_cmd_link_v", 64'(link.io_cmd_link_o[65]), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) rd(8'h0E, i, 1'b0, 64'h0);

`ifdef BP_IO_LINK_RESPONDER_STATS_EN
        do_reset();
        for (int i = 0; i < 5; i++) rd(8'h10, 1, 1'b0, 64'h0);
        rd(8'h10, 16, 1'b0, 64'd5);
        wr(8'h10, 16, 4'd1, 64'h99, 1'b1);
        rd(8'h10, 16, 1'b0, 64'd7);
`else
        do_reset();
        rd(8'h10, 16, 1'b1, 64'h0);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
